sram_ctrl_gen: RTL and testbench

Parametrised asynchronous-SRAM controller for the VGA/frame-buffer subsystem; successor to the fixed 16-bit, two-byte-lane controller. Host side: single-request valid/ready handshake with per-lane byte enables. SRAM side: drives address, data and active-low strobes with a configurable access length and bus-turnaround gap. Read data is returned with an rvalid pulse; every transaction, read or write, ends with a done pulse.

---
 rtl/sram_ctrl_gen.sv | 233 +++++++++++++++++++++++
 tb/tb_sram_ctrl_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_gen
// Purpose  : Parametrised asynchronous-SRAM controller for the frame buffer.
//            Takes single host requests over a valid/ready handshake and runs
//            one SRAM access each: WAIT_CYC strobe-active cycles, one END
//            cycle (strobes off, write data and address still held for hold
//            time), then TURN_CYC bus-turnaround cycles.
// Ports    : clk, rst (async, active-low)
//            host : req, we, addr, be, wdata -> ready, rdata, rvalid, done
//            sram : sram_addr, sram_dq (inout), sram_ce_n, sram_oe_n,
//                   sram_we_n, sram_be_n
// Revision : 1.0 - initial parametrised release
// ============================================================================
module sram_ctrl_gen #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 2,
    parameter int TURN_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  ready,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  done,
    output logic [ADDR_W-1:0]     sram_addr,
    inout  wire  [DATA_W-1:0]     sram_dq,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [DATA_W/8-1:0]   sram_be_n
);

    localparam int LANES    = DATA_W / 8;
    localparam int c_WCNT_W = $clog2(WAIT_CYC + 1);
    // A zero-cycle turnaround still needs a 1-bit counter to keep widths legal.
    localparam int c_TCNT_W = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;
    localparam logic [c_WCNT_W-1:0] c_WAIT_LOAD = c_WCNT_W'(WAIT_CYC);
    localparam logic [c_TCNT_W-1:0] c_TURN_LOAD = c_TCNT_W'(TURN_CYC);
    localparam logic [c_WCNT_W-1:0] c_WCNT_ONE  = c_WCNT_W'(1);
    localparam logic [c_TCNT_W-1:0] c_TCNT_ONE  = c_TCNT_W'(1);

    generate
        if ((DATA_W % 8 != 0) || (WAIT_CYC < 1) || (TURN_CYC < 0)) begin : g_bad_param
            $error("sram_ctrl_gen: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_ACCESS = 3'd2,
        S_END    = 3'd3,
        S_TURN   = 3'd4
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_WCNT_W-1:0]   r_wcnt, w_wcnt_nxt;
    logic [c_TCNT_W-1:0]   r_tcnt, w_tcnt_nxt;
    logic                  r_we;
    logic [LANES-1:0]      r_be;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_dq_oe, w_dq_oe_nxt;
    logic                  r_ready, w_ready_nxt;
    logic [DATA_W-1:0]     r_rdata, w_rdata_nxt;
    logic                  r_rvalid, w_rvalid_nxt;
    logic                  r_done, w_done_nxt;
    logic [ADDR_W-1:0]     r_addr, w_addr_nxt;
    logic                  r_ce_n, w_ce_n_nxt;
    logic                  r_oe_n, w_oe_n_nxt;
    logic                  r_we_n, w_we_n_nxt;
    logic [LANES-1:0]      r_be_n, w_be_n_nxt;
    logic                  w_accept;
    logic [DATA_W-1:0]     w_lane_mask;

    // Expand the latched byte enables to a bit mask so unselected read lanes
    // come back as zero regardless of what the SRAM drives on them.
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane_mask
            assign w_lane_mask[8*i +: 8] = {8{r_be[i]}};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output logic. Every output is registered, so the
    // values computed here appear on the pins one cycle later.
    always_comb begin
        w_state_nxt  = r_state;
        w_wcnt_nxt   = r_wcnt;
        w_tcnt_nxt   = r_tcnt;
        w_accept     = 1'b0;
        w_ready_nxt  = 1'b0;
        w_rvalid_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_ce_n_nxt   = 1'b1;
        w_oe_n_nxt   = 1'b1;
        w_we_n_nxt   = 1'b1;
        w_be_n_nxt   = '1;
        w_dq_oe_nxt  = 1'b0;
        w_addr_nxt   = r_addr;
        w_rdata_nxt  = r_rdata;
        case (r_state)
            S_INIT: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
            end
            S_IDLE: begin
                w_ready_nxt = 1'b1;
                if (req && r_ready) begin
                    w_accept    = 1'b1;
                    w_ready_nxt = 1'b0;
                    w_state_nxt = S_ACCESS;
                    w_wcnt_nxt  = c_WAIT_LOAD;
                    w_addr_nxt  = addr;
                    w_be_n_nxt  = ~be;
                    // An all-lanes-off request runs the full timing with the
                    // chip left deselected.
                    if (be != '0) begin
                        w_ce_n_nxt = 1'b0;
                        if (we) begin
                            w_we_n_nxt  = 1'b0;
                            w_dq_oe_nxt = 1'b1;
                        end else begin
                            w_oe_n_nxt = 1'b0;
                        end
                    end
                end
            end
            S_ACCESS: begin
                // Write data keeps driving through END for hold time.
                w_dq_oe_nxt = r_dq_oe;
                if (r_wcnt == c_WCNT_ONE) begin
                    w_state_nxt  = S_END;
                    w_done_nxt   = 1'b1;
                    w_rvalid_nxt = ~r_we;
                    if (!r_we) begin
                        w_rdata_nxt = sram_dq & w_lane_mask;
                    end
                end else begin
                    w_wcnt_nxt = r_wcnt - c_WCNT_ONE;
                    w_ce_n_nxt = r_ce_n;
                    w_oe_n_nxt = r_oe_n;
                    w_we_n_nxt = r_we_n;
                    w_be_n_nxt = r_be_n;
                end
            end
            S_END: begin
                if (TURN_CYC > 0) begin
                    w_state_nxt = S_TURN;
                    w_tcnt_nxt  = c_TURN_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                end
            end
            S_TURN: begin
                if (r_tcnt == c_TCNT_ONE) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_tcnt_nxt = r_tcnt - c_TCNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt   <= '0;
            r_tcnt   <= '0;
            r_we     <= 1'b0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_dq_oe  <= 1'b0;
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            r_addr   <= '0;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_be_n   <= '1;
        end else begin
            if (w_accept) begin
                r_we    <= we;
                r_be    <= be;
                r_wdata <= wdata;
            end
            r_wcnt   <= w_wcnt_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_dq_oe  <= w_dq_oe_nxt;
            r_ready  <= w_ready_nxt;
            r_rdata  <= w_rdata_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_done   <= w_done_nxt;
            r_addr   <= w_addr_nxt;
            r_ce_n   <= w_ce_n_nxt;
            r_oe_n   <= w_oe_n_nxt;
            r_we_n   <= w_we_n_nxt;
            r_be_n   <= w_be_n_nxt;
        end
    end

    assign sram_dq   = r_dq_oe ? r_wdata : {DATA_W{1'bz}};
    assign ready     = r_ready;
    assign rdata     = r_rdata;
    assign rvalid    = r_rvalid;
    assign done      = r_done;
    assign sram_addr = r_addr;
    assign sram_ce_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;
    assign sram_be_n = r_be_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_ctrl_gen
// Purpose  : Directed self-checking bench for sram_ctrl_gen. Instance A uses
//            the default 16-bit configuration (WAIT_CYC=2, TURN_CYC=1),
//            instance B a 32-bit one (WAIT_CYC=1, TURN_CYC=0). Each has a
//            small behavioural SRAM. The data buses are pulled high, so a
//            released bus reads as all ones.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_viol   = 0;

    // ---------------- instance A: 16-bit, WAIT 2, TURN 1 ----------------
    logic        rst_a, req_a, we_a;
    logic [17:0] addr_a;
    logic [1:0]  be_a;
    logic [15:0] wdata_a;
    logic        ready_a, rvalid_a, done_a, ce_n_a, oe_n_a, we_n_a;
    logic [15:0] rdata_a;
    logic [17:0] saddr_a;
    logic [1:0]  be_n_a;
    tri1  [15:0] dq_a;
    logic [15:0] mem_a [0:255];

    sram_ctrl_gen #(.ADDR_W(18), .DATA_W(16), .WAIT_CYC(2), .TURN_CYC(1)) u_dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .we(we_a), .addr(addr_a),
        .be(be_a), .wdata(wdata_a), .ready(ready_a), .rdata(rdata_a),
        .rvalid(rvalid_a), .done(done_a), .sram_addr(saddr_a), .sram_dq(dq_a),
        .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a), .sram_we_n(we_n_a),
        .sram_be_n(be_n_a)
    );

    assign dq_a = (!ce_n_a && !oe_n_a) ? mem_a[saddr_a[7:0]] : 16'hzzzz;

    // ---------------- instance B: 32-bit, WAIT 1, TURN 0 ----------------
    logic        rst_b, req_b, we_b;
    logic [17:0] addr_b;
    logic [3:0]  be_b;
    logic [31:0] wdata_b;
    logic        ready_b, rvalid_b, done_b, ce_n_b, oe_n_b, we_n_b;
    logic [31:0] rdata_b;
    logic [17:0] saddr_b;
    logic [3:0]  be_n_b;
    tri1  [31:0] dq_b;
    logic [31:0] mem_b [0:255];

    sram_ctrl_gen #(.ADDR_W(18), .DATA_W(32), .WAIT_CYC(1), .TURN_CYC(0)) u_dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .we(we_b), .addr(addr_b),
        .be(be_b), .wdata(wdata_b), .ready(ready_b), .rdata(rdata_b),
        .rvalid(rvalid_b), .done(done_b), .sram_addr(saddr_b), .sram_dq(dq_b),
        .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b), .sram_we_n(we_n_b),
        .sram_be_n(be_n_b)
    );

    assign dq_b = (!ce_n_b && !oe_n_b) ? mem_b[saddr_b[7:0]] : 32'hzzzzzzzz;

    // SRAM write behaviour: enabled lanes are stored while ce_n and we_n are low.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!ce_n_a && !we_n_a && !be_n_a[i]) mem_a[saddr_a[7:0]][8*i +: 8] <= dq_a[8*i +: 8];
        end
        for (int j = 0; j < 4; j++) begin
            if (!ce_n_b && !we_n_b && !be_n_b[j]) mem_b[saddr_b[7:0]][8*j +: 8] <= dq_b[8*j +: 8];
        end
    end

    // Bus hazards: write strobe overlapping output enable, or the bus not
    // carrying the SRAM's data while the SRAM is told to drive it.
    always @(negedge clk) begin
        if (!we_n_a && !oe_n_a) n_viol++;
        if (!oe_n_a && !ce_n_a && (dq_a !== mem_a[saddr_a[7:0]])) n_viol++;
        if (!we_n_b && !oe_n_b) n_viol++;
        if (!oe_n_b && !ce_n_b && (dq_b !== mem_b[saddr_b[7:0]])) n_viol++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = '0;
            mem_b[k] = '0;
        end
        rst_a = 0; req_a = 0; we_a = 0; addr_a = '0; be_a = '0; wdata_a = '0;
        rst_b = 0; req_b = 0; we_b = 0; addr_b = '0; be_b = '0; wdata_b = '0;
        tick(2);

        // ---------------- A: reset state ----------------
        check("a_rst_ready",  ready_a,  0);
        check("a_rst_ce_n",   ce_n_a,   1);
        check("a_rst_oe_n",   oe_n_a,   1);
        check("a_rst_we_n",   we_n_a,   1);
        check("a_rst_be_n",   be_n_a,   2'b11);
        check("a_rst_addr",   saddr_a,  0);
        check("a_rst_dq",     dq_a,     16'hFFFF);
        check("a_rst_rdata",  rdata_a,  0);
        check("a_rst_rvalid", rvalid_a, 0);
        check("a_rst_done",   done_a,   0);
        rst_a = 1;
        check("a_init_ready", ready_a, 0);
        tick(1);
        check("a_idle_ready", ready_a, 1);
        check("a_idle_dq",    dq_a,    16'hFFFF);

        // ---------------- A: write 0xBEEF to 0x00123 ----------------
        req_a = 1; we_a = 1; addr_a = 18'h00123; be_a = 2'b11; wdata_a = 16'hBEEF;
        tick(1);                                 // T0+1
        req_a = 0; addr_a = '0; wdata_a = '0;
        check("a_wr1_ready", ready_a, 0);
        check("a_wr1_ce_n",  ce_n_a,  0);
        check("a_wr1_we_n",  we_n_a,  0);
        check("a_wr1_oe_n",  oe_n_a,  1);
        check("a_wr1_addr",  saddr_a, 18'h00123);
        check("a_wr1_be_n",  be_n_a,  2'b00);
        check("a_wr1_dq",    dq_a,    16'hBEEF);
        tick(1);                                 // T0+2
        check("a_wr2_ce_n",  ce_n_a,  0);
        check("a_wr2_we_n",  we_n_a,  0);
        check("a_wr2_done",  done_a,  0);
        tick(1);                                 // T0+3 END
        check("a_wr3_we_n",  we_n_a,  1);
        check("a_wr3_ce_n",  ce_n_a,  1);
        check("a_wr3_be_n",  be_n_a,  2'b11);
        check("a_wr3_done",  done_a,  1);
        check("a_wr3_rvld",  rvalid_a, 0);
        check("a_wr3_dq",    dq_a,    16'hBEEF);
        check("a_wr3_addr",  saddr_a, 18'h00123);
        tick(1);                                 // T0+4 TURN
        check("a_wr4_done",  done_a,  0);
        check("a_wr4_dq",    dq_a,    16'hFFFF);
        check("a_wr4_ready", ready_a, 0);
        tick(1);                                 // T0+5 IDLE
        check("a_wr5_ready", ready_a, 1);
        check("a_wr_mem",    mem_a[8'h23], 16'hBEEF);

        // ---------------- A: read back, upper lane only ----------------
        req_a = 1; we_a = 0; addr_a = 18'h00123; be_a = 2'b10;
        tick(1);                                 // T0+1
        req_a = 0;
        check("a_rd1_oe_n", oe_n_a, 0);
        check("a_rd1_ce_n", ce_n_a, 0);
        check("a_rd1_we_n", we_n_a, 1);
        check("a_rd1_be_n", be_n_a, 2'b01);
        tick(1);                                 // T0+2
        check("a_rd2_oe_n", oe_n_a, 0);
        check("a_rd2_rvld", rvalid_a, 0);
        tick(1);                                 // T0+3
        check("a_rd3_rvld",  rvalid_a, 1);
        check("a_rd3_done",  done_a,   1);
        check("a_rd3_rdata", rdata_a,  16'hBE00);
        check("a_rd3_oe_n",  oe_n_a,   1);
        tick(1);
        check("a_rd4_rvld",  rvalid_a, 0);
        check("a_rd4_hold",  rdata_a,  16'hBE00);
        tick(1);
        check("a_rd5_ready", ready_a, 1);

        // ---------------- A: back-to-back, req held ----------------
        req_a = 1; we_a = 1; addr_a = 18'h00010; be_a = 2'b11; wdata_a = 16'h1234;
        tick(1);                                 // T0+1 (write accepted at T0)
        we_a = 0; wdata_a = 16'h0000;
        check("a_bb1_we_n", we_n_a, 0);
        tick(3);                                 // T0+4
        check("a_bb4_ready", ready_a, 0);
        check("a_bb4_oe_n",  oe_n_a,  1);
        tick(1);                                 // T0+5 second acceptance
        check("a_bb5_ready", ready_a, 1);
        tick(1);                                 // T0+6
        req_a = 0;
        check("a_bb6_oe_n", oe_n_a, 0);
        check("a_bb6_we_n", we_n_a, 1);
        tick(2);                                 // T0+8
        check("a_bb8_rvld",  rvalid_a, 1);
        check("a_bb8_rdata", rdata_a,  16'h1234);
        tick(2);
        check("a_bb_ready",  ready_a, 1);

        // ---------------- A: be=0 read ----------------
        req_a = 1; we_a = 0; addr_a = 18'h00123; be_a = 2'b00;
        tick(1);
        req_a = 0;
        check("a_be0_ce_n", ce_n_a, 1);
        check("a_be0_oe_n", oe_n_a, 1);
        check("a_be0_be_n", be_n_a, 2'b11);
        tick(2);                                 // T0+3
        check("a_be0_rvld",  rvalid_a, 1);
        check("a_be0_done",  done_a,   1);
        check("a_be0_rdata", rdata_a,  16'h0000);
        tick(2);
        check("a_be0_ready", ready_a, 1);

        // ---------------- A: reset during write ACCESS ----------------
        req_a = 1; we_a = 1; addr_a = 18'h00040; be_a = 2'b11; wdata_a = 16'h5AA5;
        tick(1);
        req_a = 0;
        check("a_ab_we_n0", we_n_a, 0);
        rst_a = 0;
        #1;
        check("a_ab_we_n", we_n_a, 1);
        check("a_ab_ce_n", ce_n_a, 1);
        check("a_ab_be_n", be_n_a, 2'b11);
        check("a_ab_dq",   dq_a,   16'hFFFF);
        for (int c = 0; c < 3; c++) begin
            tick(1);
            check("a_ab_done", done_a, 0);
        end
        rst_a = 1;
        check("a_ab_init", ready_a, 0);
        tick(1);
        check("a_ab_idle", ready_a, 1);
        check("a_ab_done2", done_a, 0);

        // ---------------- B: reset state ----------------
        check("b_rst_ready", ready_b, 0);
        check("b_rst_ce_n",  ce_n_b,  1);
        check("b_rst_be_n",  be_n_b,  4'hF);
        check("b_rst_dq",    dq_b,    32'hFFFFFFFF);
        rst_b = 1;
        check("b_init_ready", ready_b, 0);
        tick(1);
        check("b_idle_ready", ready_b, 1);

        // ---------------- B: write lanes 0 and 2 ----------------
        req_b = 1; we_b = 1; addr_b = 18'h00005; be_b = 4'b0101; wdata_b = 32'h11223344;
        tick(1);                                 // T0+1
        req_b = 0;
        check("b_wr1_we_n", we_n_b, 0);
        check("b_wr1_ce_n", ce_n_b, 0);
        check("b_wr1_be_n", be_n_b, 4'b1010);
        check("b_wr1_dq",   dq_b,   32'h11223344);
        tick(1);                                 // T0+2 END
        check("b_wr2_we_n",  we_n_b,  1);
        check("b_wr2_done",  done_b,  1);
        check("b_wr2_dq",    dq_b,    32'h11223344);
        check("b_wr2_ready", ready_b, 0);
        tick(1);                                 // T0+3 IDLE
        check("b_wr3_ready", ready_b, 1);
        check("b_wr3_dq",    dq_b,    32'hFFFFFFFF);

        // ---------------- B: read all lanes ----------------
        req_b = 1; we_b = 0; addr_b = 18'h00005; be_b = 4'b1111;
        tick(1);
        req_b = 0;
        check("b_rd1_oe_n", oe_n_b, 0);
        tick(1);
        check("b_rd2_rvld",  rvalid_b, 1);
        check("b_rd2_done",  done_b,   1);
        check("b_rd2_rdata", rdata_b,  32'h00220044);
        tick(1);
        check("b_rd3_ready", ready_b, 1);

        // ---------------- B: reset during write ACCESS ----------------
        req_b = 1; we_b = 1; addr_b = 18'h00006; be_b = 4'b0101; wdata_b = 32'h5A5A5A5A;
        tick(1);
        req_b = 0;
        check("b_ab_we_n0", we_n_b, 0);
        rst_b = 0;
        #1;
        check("b_ab_we_n", we_n_b, 1);
        check("b_ab_ce_n", ce_n_b, 1);
        check("b_ab_dq",   dq_b,   32'hFFFFFFFF);
        for (int c = 0; c < 2; c++) begin
            tick(1);
            check("b_ab_done", done_b, 0);
        end
        rst_b = 1;
        check("b_ab_init", ready_b, 0);
        tick(1);
        check("b_ab_idle", ready_b, 1);

        check("bus_hazards", n_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
